sys_timer: RTL and testbench

Free-running timebase that produces the `counter27M` and `counter1M` values the system bus returns at `COUNTER27M_ADDRESS` and `COUNTER1M_ADDRESS`. It sits directly upstream of the bus decoder: the counters feed the decoder's counter inputs, and the decoder's write strobe, address offset and write data feed back in for counter loads and compare programming. An optional microsecond compare raises a level interrupt toward the core.

---
 rtl/sys_timer.sv | 115 +++++++++++
 tb/tb_sys_timer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_timer.sv
// Free-running 27 MHz cycle counter and prescaled microsecond counter with bus loads.
// Define SYS_TIMER_COMPARE_EN to add the compare register, ctrl and cmp_irq.
module sys_timer #(
  parameter int unsigned DIVISOR = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wen,
  input  logic [3:0]  addr_off,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] counter27M,
  output logic [31:0] counter1M,
  output logic        cmp_irq
);

  localparam logic [7:0] PRE_LAST = 8'(DIVISOR - 1);

  logic [31:0] cnt27_q, cnt27_d;
  logic [31:0] cnt1_q, cnt1_d;
  logic [7:0]  pre_q, pre_d;
  logic        wr_cnt27, wr_cnt1, tick, cnt1_new;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^addr_off[1:0];
  assign wr_cnt27 = wen && (addr_off[3:2] == 2'd0);
  assign wr_cnt1  = wen && (addr_off[3:2] == 2'd1);
  assign tick     = (pre_q == PRE_LAST);

  // Loads win over the free-running increment and the prescaler tick.
  always_comb begin
    cnt27_d  = wr_cnt27 ? wdata : cnt27_q + 32'd1;
    cnt1_d   = cnt1_q;
    pre_d    = pre_q + 8'd1;
    cnt1_new = 1'b0;
    if (wr_cnt1) begin
      cnt1_d   = wdata;
      pre_d    = 8'd0;
      cnt1_new = 1'b1;
    end else if (tick) begin
      cnt1_d   = cnt1_q + 32'd1;
      pre_d    = 8'd0;
      cnt1_new = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt27_q <= 32'd0;
      cnt1_q  <= 32'd0;
      pre_q   <= 8'd0;
    end else begin
      cnt27_q <= cnt27_d;
      cnt1_q  <= cnt1_d;
      pre_q   <= pre_d;
    end
  end

  assign counter27M = cnt27_q;
  assign counter1M  = cnt1_q;

`ifdef SYS_TIMER_COMPARE_EN
  logic [31:0] compare_q;
  logic        irq_en_q, pending_q, match_q, cmp_irq_q;
  logic        wr_cmp, wr_ctrl, match_d, pending_d;

  assign wr_cmp  = wen && (addr_off[3:2] == 2'd2);
  assign wr_ctrl = wen && (addr_off[3:2] == 2'd3);

  // Only a fresh counter1M value can match; rewriting compare never does.
  assign match_d   = cnt1_new && (cnt1_d == compare_q);
  assign pending_d = match_q ? 1'b1 : ((wr_ctrl && wdata[1]) ? 1'b0 : pending_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      compare_q <= 32'd0;
      irq_en_q  <= 1'b0;
      pending_q <= 1'b0;
      match_q   <= 1'b0;
      cmp_irq_q <= 1'b0;
    end else begin
      if (wr_cmp)  compare_q <= wdata;
      if (wr_ctrl) irq_en_q  <= wdata[0];
      match_q   <= match_d;
      pending_q <= pending_d;
      cmp_irq_q <= pending_q & irq_en_q;
    end
  end

  assign cmp_irq = cmp_irq_q;

  always_comb begin
    rdata = 32'd0;
    case (addr_off[3:2])
      2'd0: rdata = cnt27_q;
      2'd1: rdata = cnt1_q;
      2'd2: rdata = compare_q;
      2'd3: rdata = {30'd0, pending_q, irq_en_q};
      default: rdata = 32'd0;
    endcase
  end
`else
  assign cmp_irq = 1'b0;

  always_comb begin
    rdata = 32'd0;
    case (addr_off[3:2])
      2'd0: rdata = cnt27_q;
      2'd1: rdata = cnt1_q;
      default: rdata = 32'd0;
    endcase
  end
`endif

endmodule

// File: tb/tb_sys_timer.sv
// Self-checking bench for sys_timer; counters are predicted from load anchors
// with plain arithmetic (value = base + elapsed edges / DIVISOR).
module tb_sys_timer;

  localparam int unsigned D = 27;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wen = 1'b0;
  logic [3:0]  addr_off = 4'd0;
  logic [31:0] wdata = 32'd0;
  wire  [31:0] rdata, counter27M, counter1M;
  wire         cmp_irq;

  int n_tests = 0;
  int n_fail  = 0;

  longint      edges = 0;
  longint      a27 = 0, a1 = 0;
  logic [31:0] b27 = 0, b1 = 0;

  always #5 clk = ~clk;

  sys_timer #(.DIVISOR(D)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .addr_off(addr_off), .wdata(wdata),
    .rdata(rdata), .counter27M(counter27M), .counter1M(counter1M), .cmp_irq(cmp_irq)
  );

  function automatic logic [31:0] exp27();
    return b27 + 32'(edges - a27);
  endfunction

  function automatic logic [31:0] exp1();
    return b1 + 32'((edges - a1) / longint'(D));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    addr_off = a;
    #1;
    d = rdata;
  endtask

  // Drive one bus cycle; the model re-anchors on the edge that performs a load.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic en);
    wen = en; addr_off = a; wdata = d;
    step();
    wen = 1'b0;
    if (en && a[3:2] == 2'd0) begin b27 = d; a27 = edges; end
    if (en && a[3:2] == 2'd1) begin b1 = d; a1 = edges; end
  endtask

  task automatic check_counters(input string tag);
    n_tests++;
    if (counter27M !== exp27()) begin
      n_fail++;
      $display("FAIL %s counter27M edge=%0d got=%h exp=%h", tag, edges, counter27M, exp27());
    end
    n_tests++;
    if (counter1M !== exp1()) begin
      n_fail++;
      $display("FAIL %s counter1M edge=%0d got=%h exp=%h", tag, edges, counter1M, exp1());
    end
  endtask

  task automatic do_reset();
    wen = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    edges = 0; a27 = 0; a1 = 0; b27 = 0; b1 = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    repeat (2) step();
    n_tests++;
    if (counter27M !== 0 || counter1M !== 0 || cmp_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h/%h/%b exp=0/0/0", counter27M, counter1M, cmp_irq);
    end
    for (int i = 0; i < 4; i++) begin
      rd(4'(i * 4), d);
      n_tests++;
      if (d !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_rdata off=%0h got=%h exp=0", i * 4, d);
      end
    end
    do_reset();
    $display("[TB] reset checked");
  endtask

  task automatic test_free_run();
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      step();
      check_counters("free_run");
      if (i == 26 || i == 27) begin
        n_tests++;
        if (counter1M !== ((i == 27) ? 32'd1 : 32'd0)) begin
          n_fail++;
          $display("FAIL first_tick edge=%0d got=%h", i, counter1M);
        end
      end
    end
    n_tests++;
    if (counter27M !== 32'd100 || counter1M !== 32'd3) begin
      n_fail++;
      $display("FAIL free_run_100 got=%0d/%0d exp=100/3", counter27M, counter1M);
    end
    $display("[TB] free run 100 cycles: counter27M=%0d counter1M=%0d", counter27M, counter1M);
  endtask

  task automatic test_wrap();
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFFE; want[1] = 32'hFFFF_FFFF; want[2] = 32'h0;
    bus_write(4'h0, 32'hFFFF_FFFE, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      n_tests++;
      if (counter27M !== want[i]) begin
        n_fail++;
        $display("FAIL wrap step=%0d got=%h exp=%h", i, counter27M, want[i]);
      end
      check_counters("wrap");
    end
    $display("[TB] counter27M wrap load/run done");
  endtask

  task automatic test_load_on_tick();
    do_reset();
    repeat (26) step();
    bus_write(4'h4, 32'h10, 1'b1);
    n_tests++;
    if (counter1M !== 32'h10) begin
      n_fail++;
      $display("FAIL load_on_tick got=%h exp=00000010", counter1M);
    end
    for (int i = 1; i <= 27; i++) begin
      step();
      check_counters("after_load_tick");
    end
    n_tests++;
    if (counter1M !== 32'h11) begin
      n_fail++;
      $display("FAIL next_tick_after_load got=%h exp=00000011", counter1M);
    end
    $display("[TB] load on tick cycle: counter1M=%h", counter1M);
  endtask

  task automatic test_random_ops();
    logic [31:0] d, v;
    logic [3:0]  a;
    int          kind;
    do_reset();
    for (int op = 0; op < 40; op++) begin
      kind = int'($urandom_range(0, 3));
      v = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      case (kind)
        0: for (int k = 0; k < int'($urandom_range(1, 60)); k++) begin
             step();
             check_counters("rand_idle");
           end
        1: begin a = {2'd0, 2'($urandom)}; bus_write(a, v, 1'b1); check_counters("rand_wr27"); end
        2: begin a = {2'd1, 2'($urandom)}; bus_write(a, v, 1'b1); check_counters("rand_wr1"); end
        default: begin a = 4'($urandom); bus_write(a, v, 1'b0); check_counters("rand_nowen"); end
      endcase
      rd({1'b0, op[0], 2'($urandom)}, d);
      n_tests++;
      if (d !== (op[0] ? exp1() : exp27())) begin
        n_fail++;
        $display("FAIL rand_rdata op=%0d got=%h exp=%h", op, d, op[0] ? exp1() : exp27());
      end
      $display("[TB] rand op=%0d kind=%0d val=%h c27=%h c1=%h", op, kind, v, counter27M, counter1M);
    end
  endtask

`ifdef SYS_TIMER_COMPARE_EN
  task automatic test_compare_irq();
    logic [31:0] d;
    longint      e, c;
    do_reset();
    bus_write(4'h8, 32'd5, 1'b1);
    bus_write(4'hC, 32'd1, 1'b1);
    e = a1 + 5 * longint'(D);
    while (edges < e + 20) begin
      step();
      rd(4'hC, d);
      n_tests++;
      if (d[1] !== (edges >= e + 1) || cmp_irq !== (edges >= e + 2)) begin
        n_fail++;
        $display("FAIL cmp_timing edge=%0d got pend=%b irq=%b exp pend=%b irq=%b",
                 edges, d[1], cmp_irq, edges >= e + 1, edges >= e + 2);
      end
    end
    bus_write(4'hC, 32'd3, 1'b1);
    c = edges;
    rd(4'hC, d);
    n_tests++;
    if (d !== 32'd1 || cmp_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_edge ctrl=%h irq=%b exp ctrl=1 irq=1", d, cmp_irq);
    end
    step();
    n_tests++;
    if (cmp_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_irq edge=%0d got=%b exp=0", edges - c, cmp_irq);
    end
    rd(4'h8, d);
    n_tests++;
    if (d !== 32'd5) begin
      n_fail++;
      $display("FAIL compare_readback got=%h exp=5", d);
    end
    $display("[TB] compare=5 irq raised at edge %0d and cleared", e + 2);
  endtask

  task automatic test_irq_masked();
    logic [31:0] d;
    longint      e;
    do_reset();
    bus_write(4'h8, 32'd2, 1'b1);
    bus_write(4'hC, 32'd0, 1'b1);
    e = a1 + 2 * longint'(D);
    while (edges < e + 5) begin
      step();
      rd(4'hC, d);
      n_tests++;
      if (d[1] !== (edges >= e + 1) || cmp_irq !== 1'b0) begin
        n_fail++;
        $display("FAIL masked edge=%0d got pend=%b irq=%b exp pend=%b irq=0",
                 edges, d[1], cmp_irq, edges >= e + 1);
      end
    end
    bus_write(4'hC, 32'd1, 1'b1);
    n_tests++;
    if (cmp_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL unmask_early got=%b exp=0", cmp_irq);
    end
    step();
    n_tests++;
    if (cmp_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL unmask_irq got=%b exp=1", cmp_irq);
    end
    $display("[TB] masked match then irq_en set: cmp_irq=%b", cmp_irq);
  endtask

  task automatic test_match_on_load();
    logic [31:0] x, d;
    do_reset();
    x = $urandom | 32'h100;
    bus_write(4'h8, x, 1'b1);
    bus_write(4'hC, 32'd1, 1'b1);
    bus_write(4'h4, x, 1'b1);
    step();
    rd(4'hC, d);
    n_tests++;
    if (d[1] !== 1'b1 || cmp_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL load_match_pend got pend=%b irq=%b exp 1/0", d[1], cmp_irq);
    end
    step();
    n_tests++;
    if (cmp_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL load_match_irq got=%b exp=1", cmp_irq);
    end
    $display("[TB] match by load of %h: cmp_irq=%b", x, cmp_irq);
  endtask
`else
  task automatic test_no_compare();
    logic [31:0] d;
    do_reset();
    bus_write(4'h8, $urandom, 1'b1);
    bus_write(4'hC, 32'd3, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      rd((i[0]) ? 4'hC : 4'h8, d);
      n_tests++;
      if (d !== 32'd0 || cmp_irq !== 1'b0) begin
        n_fail++;
        $display("FAIL no_compare off=%0h got=%h irq=%b exp 0/0", i[0] ? 12 : 8, d, cmp_irq);
      end
      check_counters("no_compare");
    end
    $display("[TB] compare disabled: 0x8/0xC read 0, cmp_irq=0");
  endtask
`endif

  task automatic test_async_reset();
    logic [31:0] d;
    do_reset();
    repeat (int'($urandom_range(30, 300))) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (counter27M !== 0 || counter1M !== 0 || cmp_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got=%h/%h/%b exp=0/0/0", counter27M, counter1M, cmp_irq);
    end
    repeat (2) step();
    for (int i = 0; i < 4; i++) begin
      rd(4'(i * 4), d);
      n_tests++;
      if (d !== 32'd0) begin
        n_fail++;
        $display("FAIL held_reset_rdata off=%0h got=%h exp=0", i * 4, d);
      end
    end
    rst_n = 1'b1;
    edges = 0; a27 = 0; a1 = 0; b27 = 0; b1 = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      check_counters("post_reset");
    end
    $display("[TB] async reset mid-count: restart c27=%0d c1=%0d", counter27M, counter1M);
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_wrap();
    test_load_on_tick();
    test_random_ops();
`ifdef SYS_TIMER_COMPARE_EN
    test_compare_irq();
    test_irq_masked();
    test_match_on_load();
`else
    test_no_compare();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
